// File: rtl/reorder_buffer_pkg.sv
// Shared core package for the reorder buffer.
// Holds the default buffer geometry, the register field widths and the
// per-entry record layout used by reorder_buffer.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH      = 16;
  localparam int ROB_DEPTH_BITS = 4;
  localparam int LOG_RW_W       = 5;
  localparam int PHY_RW_W       = 6;

  // One reorder-buffer slot. valid marks an allocated slot, done marks
  // that execution has written it back and it may retire once at head.
  typedef struct packed {
    logic                valid;
    logic                done;
    logic                uses_rw;
    logic [LOG_RW_W-1:0] log_rw;
    logic [PHY_RW_W-1:0] phy_rw;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer.
// Rename allocates entries at the tail, execution marks entries done by tag,
// and the head entry retires (one per cycle) once it is done. A flush empties
// the buffer in one cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   alloc_valid         allocation request from rename
//   alloc_uses_rw       instruction writes a destination register
//   alloc_log_rw        logical destination register
//   alloc_phy_rw        physical destination register
//   alloc_ready         buffer not full
//   alloc_tag           tag the next allocation receives (tail pointer)
//   wb_valid, wb_tag    completion of one entry
//   flush               discard every entry
//   commit_en           head entry retires this cycle
//   commit_wr_en        retiring entry writes a non-zero logical register
//   commit_phy          physical destination of retiring entry
//   commit_log          logical destination of retiring entry
//   count, empty        occupancy
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = ROB_DEPTH_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_valid,
  input  logic                alloc_uses_rw,
  input  logic [LOG_RW_W-1:0] alloc_log_rw,
  input  logic [PHY_RW_W-1:0] alloc_phy_rw,
  output logic                alloc_ready,
  output logic [TAG_W-1:0]    alloc_tag,
  input  logic                wb_valid,
  input  logic [TAG_W-1:0]    wb_tag,
  input  logic                flush,
  output logic                commit_en,
  output logic                commit_wr_en,
  output logic [PHY_RW_W-1:0] commit_phy,
  output logic [LOG_RW_W-1:0] commit_log,
  output logic [TAG_W:0]      count,
  output logic                empty
);

  rob_entry_t           entry_reg [DEPTH];
  logic [TAG_W-1:0]     head_reg;
  logic [TAG_W-1:0]     tail_reg;
  logic [TAG_W:0]       count_reg;
  logic [TAG_W:0]       count_next;

  rob_entry_t           head_entry;
  logic                 alloc_fire;
  logic [DEPTH-1:0]     commit_hit;
  logic [DEPTH-1:0]     alloc_hit;
  logic [DEPTH-1:0]     wb_hit;

  assign head_entry  = entry_reg[head_reg];

  // No bypass from a same-cycle commit: a full buffer stays full this cycle.
  assign alloc_ready = (count_reg != (TAG_W+1)'(DEPTH));
  assign alloc_fire  = alloc_valid & alloc_ready & ~flush;
  assign alloc_tag   = tail_reg;
  assign count       = count_reg;
  assign empty       = (count_reg == '0);

  // An empty buffer has no valid head, so commit_en stays low there.
  assign commit_en    = head_entry.valid & head_entry.done & ~flush;
  assign commit_wr_en = commit_en & head_entry.uses_rw & (head_entry.log_rw != '0);
  assign commit_phy   = commit_en ? head_entry.phy_rw : '0;
  assign commit_log   = commit_en ? head_entry.log_rw : '0;

  // Per-slot decode of the three events that can touch an entry.
  // A writeback to the slot retiring this cycle is dropped so it cannot
  // resurrect the done bit after the clear.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign commit_hit[gi] = commit_en  && (head_reg == TAG_W'(gi));
      assign alloc_hit[gi]  = alloc_fire && (tail_reg == TAG_W'(gi));
      assign wb_hit[gi]     = wb_valid && (wb_tag == TAG_W'(gi)) &&
                              entry_reg[gi].valid && !commit_hit[gi];
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({alloc_fire, commit_en})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_hit[i]) begin
          entry_reg[i].valid <= 1'b0;
          entry_reg[i].done  <= 1'b0;
        end
        if (wb_hit[i]) begin
          entry_reg[i].done <= 1'b1;
        end
        // The tail slot is never valid while alloc_ready is high, so this
        // cannot collide with a commit or writeback of a live entry.
        if (alloc_hit[i]) begin
          entry_reg[i] <= '{valid:   1'b1,
                            done:    1'b0,
                            uses_rw: alloc_uses_rw,
                            log_rw:  alloc_log_rw,
                            phy_rw:  alloc_phy_rw};
        end
      end
      if (commit_en)  head_reg <= head_reg + 1'b1;
      if (alloc_fire) tail_reg <= tail_reg + 1'b1;
      count_reg <= count_next;
    end
  end

endmodule
